// File: rtl/pkt_lane_serializer.sv
// Serializes a NUM_LANES-wide beat into a byte stream, one lane per cycle,
// with back-to-back beat capture on the last lane and a wrapping byte counter.
module pkt_lane_serializer #(
  parameter int OUTPUT_WIDTH = 8,
  parameter int NUM_LANES    = 8,
  parameter int LANE_ORDER   = 0,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [OUTPUT_WIDTH-1:0] pkt_tdata_i [NUM_LANES],
  input  logic                    pkt_tvalid_i,
  output logic                    pkt_tready_o,
  output logic [OUTPUT_WIDTH-1:0] byte_o,
  output logic                    byte_valid_o,
  input  logic                    byte_ready_i,
  output logic                    byte_first_o,
  output logic [COUNT_WIDTH-1:0]  byte_count_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and data is held stable while valid && !ready.

  localparam int LW      = $clog2(NUM_LANES);
  localparam int FIRST_I = (LANE_ORDER != 0) ? NUM_LANES - 1 : 0;
  localparam int LAST_I  = (LANE_ORDER != 0) ? 0 : NUM_LANES - 1;
  localparam logic [LW-1:0] FIRST_LANE = LW'(FIRST_I);
  localparam logic [LW-1:0] LAST_LANE  = LW'(LAST_I);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [OUTPUT_WIDTH-1:0] hold_q [NUM_LANES];
  logic [COUNT_WIDTH-1:0]  count_q;
  logic                    load;
  logic                    on_last;

  assign on_last = (lane_q == LAST_LANE);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    load         = 1'b0;
    // Combinational from byte_ready_i so a new beat lands with no bubble.
    pkt_tready_o = (state_q == EMPTY) || (on_last && byte_ready_i);
    case (state_q)
      EMPTY: begin
        if (pkt_tvalid_i) begin
          load    = 1'b1;
          lane_d  = FIRST_LANE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (byte_ready_i) begin
          if (!on_last) begin
            lane_d = (LANE_ORDER != 0) ? lane_q - LW'(1) : lane_q + LW'(1);
          end else if (pkt_tvalid_i) begin
            load   = 1'b1;
            lane_d = FIRST_LANE;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      lane_q  <= FIRST_LANE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (byte_valid_o && byte_ready_i) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  // Hold register contents are don't-care until a beat is captured.
  always_ff @(posedge clk_i) begin
    if (load) hold_q <= pkt_tdata_i;
  end

  assign byte_valid_o = (state_q == SHIFT);
  assign byte_o       = hold_q[lane_q];
  assign byte_first_o = (state_q == SHIFT) && (lane_q == FIRST_LANE);
  assign byte_count_o = count_q;

endmodule

// File: tb/tb_pkt_lane_serializer.sv
// Bench for pkt_lane_serializer: three instances (default, reversed lane order,
// 4-bit counter) share the same stimulus and are checked every cycle.
module tb_pkt_lane_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdata [8];
  logic       tvalid;
  logic       rdy;

  logic       tready_a, tready_b, tready_c;
  logic [7:0] byte_a, byte_b, byte_c;
  logic       valid_a, valid_b, valid_c;
  logic       first_a, first_b, first_c;
  logic [31:0] count_a, count_b;
  logic [3:0]  count_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pkt_lane_serializer #(.LANE_ORDER(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .pkt_tdata_i(tdata), .pkt_tvalid_i(tvalid),
    .pkt_tready_o(tready_a), .byte_o(byte_a), .byte_valid_o(valid_a),
    .byte_ready_i(rdy), .byte_first_o(first_a), .byte_count_o(count_a));

  pkt_lane_serializer #(.LANE_ORDER(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .pkt_tdata_i(tdata), .pkt_tvalid_i(tvalid),
    .pkt_tready_o(tready_b), .byte_o(byte_b), .byte_valid_o(valid_b),
    .byte_ready_i(rdy), .byte_first_o(first_b), .byte_count_o(count_b));

  pkt_lane_serializer #(.COUNT_WIDTH(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .pkt_tdata_i(tdata), .pkt_tvalid_i(tvalid),
    .pkt_tready_o(tready_c), .byte_o(byte_c), .byte_valid_o(valid_c),
    .byte_ready_i(rdy), .byte_first_o(first_c), .byte_count_o(count_c));

  // One cycle: inputs driven during the cycle, outputs expected before its edge.
  typedef struct {
    logic        tv;
    logic [7:0]  base;
    logic        rdy;
    logic        e_valid;
    logic [7:0]  e_byte;
    logic        e_first;
    logic        e_tready;
    logic [31:0] e_count;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic tv, input logic [7:0] base, input logic r,
                              input logic ev, input logic [7:0] eb, input logic ef,
                              input logic et, input int ec);
    vec_t v;
    v.tv = tv; v.base = base; v.rdy = r;
    v.e_valid = ev; v.e_byte = eb; v.e_first = ef; v.e_tready = et; v.e_count = 32'(ec);
    vq.push_back(v);
  endfunction

  // Eight lanes of a beat with ready always high; upstream may present the next beat.
  function automatic void add_beat(input logic [7:0] base, input logic nxt_v,
                                   input logic [7:0] nxt, input int c0);
    for (int k = 0; k < 8; k++)
      add(nxt_v, nxt, 1'b1, 1'b1, base + 8'(k), (k == 0), (k == 7), c0 + k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [7:0] rev;
    @(negedge clk);
    tvalid = v.tv;
    rdy    = v.rdy;
    for (int i = 0; i < 8; i++) tdata[i] = v.tv ? v.base + 8'(i) : 8'hEE;
    #1;
    rev = {v.e_byte[7:3], 3'd7 - v.e_byte[2:0]};
    chk("valid_a", 32'(valid_a), 32'(v.e_valid));
    chk("valid_b", 32'(valid_b), 32'(v.e_valid));
    chk("valid_c", 32'(valid_c), 32'(v.e_valid));
    chk("tready_a", 32'(tready_a), 32'(v.e_tready));
    chk("tready_b", 32'(tready_b), 32'(v.e_tready));
    chk("tready_c", 32'(tready_c), 32'(v.e_tready));
    chk("first_a", 32'(first_a), 32'(v.e_first));
    chk("first_b", 32'(first_b), 32'(v.e_first));
    chk("count_a", count_a, v.e_count);
    chk("count_b", count_b, v.e_count);
    chk("count_c", 32'(count_c), v.e_count & 32'hF);
    if (v.e_valid) begin
      chk("byte_a", 32'(byte_a), 32'(v.e_byte));
      chk("byte_b", 32'(byte_b), 32'(rev));
      chk("byte_c", 32'(byte_c), 32'(v.e_byte));
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) apply(vq[i]);
    vq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid_a"}, 32'(valid_a), 32'd0);
    chk({tag, "_valid_b"}, 32'(valid_b), 32'd0);
    chk({tag, "_valid_c"}, 32'(valid_c), 32'd0);
    chk({tag, "_first_a"}, 32'(first_a), 32'd0);
    chk({tag, "_count_a"}, count_a, 32'd0);
    chk({tag, "_count_b"}, count_b, 32'd0);
    chk({tag, "_count_c"}, 32'(count_c), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    tvalid = 1'b0;
    rdy    = 1'b0;
    for (int i = 0; i < 8; i++) tdata[i] = 8'h00;
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tready_a", 32'(tready_a), 32'd1);

    // Single beat, then idle.
    add(1, 8'h00, 1, 0, 8'h00, 0, 1, 0);
    add_beat(8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1, 8);

    // Two back-to-back beats; the early tvalid for 0x10 must be ignored until lane 7.
    add(1, 8'h00, 1, 0, 8'h00, 0, 1, 8);
    add_beat(8'h00, 1, 8'h10, 8);
    add_beat(8'h10, 0, 8'h00, 16);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1, 24);

    // Backpressure on lane 3 for three cycles, then one stall on the last lane.
    add(1, 8'h00, 1, 0, 8'h00, 0, 1, 24);
    for (int k = 0; k < 3; k++) add(0, 8'h00, 1, 1, 8'(k), (k == 0), 0, 24 + k);
    for (int k = 0; k < 3; k++) add(0, 8'h00, 0, 1, 8'h03, 0, 0, 27);
    for (int k = 3; k < 7; k++) add(0, 8'h00, 1, 1, 8'(k), 0, 0, 24 + k);
    add(1, 8'h20, 0, 1, 8'h07, 0, 0, 31);
    add(0, 8'h00, 1, 1, 8'h07, 0, 1, 31);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1, 32);

    // Start a beat and stop after lane 3 has handshaken.
    add(1, 8'h00, 1, 0, 8'h00, 0, 1, 32);
    for (int k = 0; k < 4; k++) add(0, 8'h00, 1, 1, 8'(k), (k == 0), 0, 32 + k);
    run_table();

    // Asynchronous reset mid-beat, no clock edge in between.
    @(posedge clk);
    #2;
    chk("pre_rst_byte_a", 32'(byte_a), 32'h04);
    chk("pre_rst_count_a", count_a, 32'd36);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    add(1, 8'hA0, 1, 0, 8'h00, 0, 1, 0);
    add_beat(8'hA0, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1, 8);
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
